// File: rtl/uart_tx_fifo.sv
// Byte FIFO that queues CPU console output and feeds uart_tx through its ready/write handshake.
// Optional CR insertion before every LF is compiled in with `define UART_TX_FIFO_CRLF_EN.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            wr_data_i,
  input  logic                  wr_en_i,
  input  logic                  flush_i,
  input  logic                  ovf_clr_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  overflow_o,
  output logic [7:0]            uart_data_o,
  output logic                  uart_write_o,
  input  logic                  uart_ready_i
);

  localparam int PTR_W = DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_PULSE = 1'b1
  } state_e;

  logic [7:0]       mem_q [DEPTH];

  state_e           state_q, state_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       data_q, data_d;
`ifdef UART_TX_FIFO_CRLF_EN
  logic             lf_pending_q, lf_pending_d;
`endif

  logic             push;
  logic             drop;
  logic             issue;
  logic             pop;
  logic [7:0]       head;

  always_comb begin
    state_d  = S_IDLE;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
`ifdef UART_TX_FIFO_CRLF_EN
    lf_pending_d = lf_pending_q;
`endif
    pop      = 1'b0;
    head     = mem_q[rd_ptr_q];

    // Full/empty are the registered flags, so a same-cycle pop never makes room
    // and a byte pushed into an empty FIFO is not issued until the next cycle.
    push  = wr_en_i && !full_q && !flush_i;
    drop  = wr_en_i && full_q && !flush_i;
    issue = uart_ready_i && !empty_q && (state_q == S_IDLE) && !flush_i;

    if (issue) begin
      state_d = S_PULSE;
`ifdef UART_TX_FIFO_CRLF_EN
      if ((head == 8'h0A) && !lf_pending_q) begin
        data_d       = 8'h0D;
        lf_pending_d = 1'b1;
      end else begin
        data_d       = head;
        pop          = 1'b1;
        lf_pending_d = 1'b0;
      end
`else
      data_d = head;
      pop    = 1'b1;
`endif
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    level_d = level_q + LVL_W'(push) - LVL_W'(pop);

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
`ifdef UART_TX_FIFO_CRLF_EN
      lf_pending_d = 1'b0;
`endif
    end

    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);

    // A drop in the same cycle as a clear leaves the flag set.
    if (drop)           ovf_d = 1'b1;
    else if (ovf_clr_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      data_q   <= 8'h00;
`ifdef UART_TX_FIFO_CRLF_EN
      lf_pending_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      data_q   <= data_d;
`ifdef UART_TX_FIFO_CRLF_EN
      lf_pending_q <= lf_pending_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign full_o       = full_q;
  assign empty_o      = empty_q;
  assign level_o      = level_q;
  assign overflow_o   = ovf_q;
  assign uart_data_o  = data_q;
  assign uart_write_o = (state_q == S_PULSE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset, ordering, latency, overflow, flush, wrap and LF handling.
module tb_uart_tx_fifo;
  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                reset;
  logic [7:0]          wr_data;
  logic                wr_en;
  logic                flush;
  logic                ovf_clr;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] level;
  logic                overflow;
  logic [7:0]          uart_data;
  logic                uart_write;
  logic                uart_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  // Transmitter model: busy for 20 cycles after every write pulse.
  logic ready_en;
  int   busy_cnt;
  assign uart_ready = ready_en && (busy_cnt == 0);

  logic [7:0] tx_q [$];
  int         dbl_pulse;
  logic       prev_wr;

  uart_tx_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_data_i    (wr_data),
    .wr_en_i      (wr_en),
    .flush_i      (flush),
    .ovf_clr_i    (ovf_clr),
    .full_o       (full),
    .empty_o      (empty),
    .level_o      (level),
    .overflow_o   (overflow),
    .uart_data_o  (uart_data),
    .uart_write_o (uart_write),
    .uart_ready_i (uart_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset)           busy_cnt <= 0;
    else if (uart_write) busy_cnt <= 20;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  initial dbl_pulse = 0;
  always @(negedge clk) begin
    if (reset) prev_wr <= 1'b0;
    else begin
      if (uart_write === 1'b1) begin
        tx_q.push_back(uart_data);
        if (prev_wr) dbl_pulse <= dbl_pulse + 1;
      end
      prev_wr <= uart_write;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (uart_write === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (empty === 1'b1 && uart_write === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s drain timeout: level=%0d required 0 within %0d cycles", name, level, budget);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic check_tx(input string name, input int base, input logic [7:0] exp_b [], input int n);
    logic [7:0] got;
    tests_run++;
    if (tx_q.size() - base !== n) begin
      tests_failed++;
      $display("FAIL %s count: got %0d required %0d", name, tx_q.size() - base, n);
    end
    for (int i = 0; i < n; i++) begin
      got = (base + i < tx_q.size()) ? tx_q[base + i] : 8'hxx;
      tests_run++;
      if (got !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL %s byte[%0d]: got %h required %h", name, i, got, exp_b[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; ovf_clr = 1'b0; ready_en = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    tests_run += 6;
    if (empty !== 1'b1)      begin tests_failed++; $display("FAIL reset_empty: got %b required 1", empty); end
    if (full !== 1'b0)       begin tests_failed++; $display("FAIL reset_full: got %b required 0", full); end
    if (level !== 5'd0)      begin tests_failed++; $display("FAIL reset_level: got %0d required 0", level); end
    if (overflow !== 1'b0)   begin tests_failed++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    if (uart_write !== 1'b0) begin tests_failed++; $display("FAIL reset_write: got %b required 0", uart_write); end
    if (uart_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h required 00", uart_data); end
  endtask

  task automatic test_order();
    int base;
    logic [7:0] exp_b [] = '{8'h41, 8'h42, 8'h43};
    base = tx_q.size();
    ready_en = 1'b0;
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    tests_run++;
    if (level !== 5'd3) begin tests_failed++; $display("FAIL order_level3: got %0d required 3", level); end
    ready_en = 1'b1;
    wait_drain("order", 200);
    check_tx("order", base, exp_b, 3);
    tests_run++;
    if (level !== 5'd0) begin tests_failed++; $display("FAIL order_level0: got %0d required 0", level); end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 50 && uart_ready !== 1'b1; i++) tick();
    wr_en = 1'b1; wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    tests_run += 2;
    if (uart_write !== 1'b0) begin tests_failed++; $display("FAIL latency_early: got write=%b required 0", uart_write); end
    if (level !== 5'd1)      begin tests_failed++; $display("FAIL latency_level: got %0d required 1", level); end
    tick();
    tests_run += 3;
    if (uart_write !== 1'b1) begin tests_failed++; $display("FAIL latency_write: got %b required 1", uart_write); end
    if (uart_data !== 8'h5A) begin tests_failed++; $display("FAIL latency_data: got %h required 5a", uart_data); end
    if (level !== 5'd0)      begin tests_failed++; $display("FAIL latency_pop: got %0d required 0", level); end
    tick();
    tests_run++;
    if (uart_write !== 1'b0) begin tests_failed++; $display("FAIL latency_width: got %b required 0", uart_write); end
    wait_drain("latency", 60);
  endtask

  task automatic test_overflow();
    int base;
    logic [7:0] exp_b [];
    exp_b = new[DEPTH];
    for (int i = 0; i < DEPTH; i++) exp_b[i] = 8'h10 + 8'(i);
    base = tx_q.size();
    ready_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
    tests_run += 3;
    if (full !== 1'b1)       begin tests_failed++; $display("FAIL ovf_full: got %b required 1", full); end
    if (level !== 5'd16)     begin tests_failed++; $display("FAIL ovf_level: got %0d required 16", level); end
    if (overflow !== 1'b0)   begin tests_failed++; $display("FAIL ovf_early: got %b required 0", overflow); end
    push_byte(8'h20);
    tests_run += 2;
    if (overflow !== 1'b1)   begin tests_failed++; $display("FAIL ovf_set: got %b required 1", overflow); end
    if (level !== 5'd16)     begin tests_failed++; $display("FAIL ovf_level_hold: got %0d required 16", level); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    tests_run++;
    if (overflow !== 1'b0)   begin tests_failed++; $display("FAIL ovf_clr: got %b required 0", overflow); end
    ovf_clr = 1'b1; push_byte(8'h55); ovf_clr = 1'b0;
    tests_run++;
    if (overflow !== 1'b1)   begin tests_failed++; $display("FAIL ovf_set_wins: got %b required 1", overflow); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    ready_en = 1'b1;
    wait_drain("overflow", 600);
    check_tx("overflow", base, exp_b, DEPTH);
  endtask

  task automatic test_flush();
    int base;
    base = tx_q.size();
    ready_en = 1'b0;
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
    tests_run++;
    if (level !== 5'd5) begin tests_failed++; $display("FAIL flush_pre_level: got %0d required 5", level); end
    wr_en = 1'b1; wr_data = 8'h35; flush = 1'b1;
    tick();
    wr_en = 1'b0; flush = 1'b0;
    tests_run += 3;
    if (level !== 5'd0)    begin tests_failed++; $display("FAIL flush_level: got %0d required 0", level); end
    if (empty !== 1'b1)    begin tests_failed++; $display("FAIL flush_empty: got %b required 1", empty); end
    if (overflow !== 1'b0) begin tests_failed++; $display("FAIL flush_overflow: got %b required 0", overflow); end
    ready_en = 1'b1;
    repeat (30) tick();
    tests_run++;
    if (tx_q.size() != base) begin
      tests_failed++;
      $display("FAIL flush_no_tx: got %0d writes required 0", tx_q.size() - base);
    end
  endtask

  task automatic test_wrap();
    int base;
    bit ok;
    logic [7:0] exp_b [];
    exp_b = new[DEPTH + 8];
    for (int i = 0; i < DEPTH; i++) exp_b[i] = 8'h80 + 8'(i);
    for (int k = 0; k < 8; k++) exp_b[DEPTH + k] = 8'h90 + 8'(k);
    ready_en = 1'b1;
    for (int i = 0; i < 3; i++) push_byte(8'h70 + 8'(i));
    wait_drain("wrap_offset", 200);
    ready_en = 1'b0;
    repeat (25) tick();
    base = tx_q.size();
    for (int i = 0; i < DEPTH; i++) push_byte(8'h80 + 8'(i));
    tests_run++;
    if (full !== 1'b1) begin tests_failed++; $display("FAIL wrap_full: got %b required 1", full); end
    // Issue and push in the same cycle while full: the push must still be dropped.
    ready_en = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    tests_run += 3;
    if (uart_write !== 1'b1) begin tests_failed++; $display("FAIL wrap_issue: got %b required 1", uart_write); end
    if (overflow !== 1'b1)   begin tests_failed++; $display("FAIL wrap_drop: got %b required 1", overflow); end
    if (level !== 5'd15)     begin tests_failed++; $display("FAIL wrap_level: got %0d required 15", level); end
    for (int k = 0; k < 8; k++) begin
      push_byte(8'h90 + 8'(k));
      wait_pulse(60, ok);
      tests_run++;
      if (!ok) begin tests_failed++; $display("FAIL wrap_pulse%0d: got no write required write", k); end
    end
    wait_drain("wrap", 600);
    check_tx("wrap", base, exp_b, DEPTH + 8);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
  endtask

`ifdef UART_TX_FIFO_CRLF_EN
  task automatic test_crlf();
    bit ok;
    logic [7:0] exp_d [3] = '{8'h68, 8'h0D, 8'h0A};
    logic [4:0] exp_l [3] = '{5'd1, 5'd1, 5'd0};
    ready_en = 1'b0;
    repeat (25) tick();
    push_byte(8'h68); push_byte(8'h0A);
    tests_run++;
    if (level !== 5'd2) begin tests_failed++; $display("FAIL crlf_level2: got %0d required 2", level); end
    ready_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_pulse(60, ok);
      tests_run += 3;
      if (!ok) begin tests_failed++; $display("FAIL crlf_pulse%0d: got no write required write", i); end
      if (uart_data !== exp_d[i]) begin tests_failed++; $display("FAIL crlf_data%0d: got %h required %h", i, uart_data, exp_d[i]); end
      if (level !== exp_l[i]) begin tests_failed++; $display("FAIL crlf_lvl%0d: got %0d required %0d", i, level, exp_l[i]); end
    end
    wait_drain("crlf", 60);
  endtask
`else
  task automatic test_lf_passthrough();
    int base;
    logic [7:0] exp_b [] = '{8'h0A};
    base = tx_q.size();
    ready_en = 1'b1;
    push_byte(8'h0A);
    wait_drain("lf", 100);
    check_tx("lf", base, exp_b, 1);
  endtask
`endif

  initial begin
    test_reset();
    test_order();
    test_latency();
    test_overflow();
    test_flush();
    test_wrap();
`ifdef UART_TX_FIFO_CRLF_EN
    test_crlf();
`else
    test_lf_passthrough();
`endif
    tests_run++;
    if (dbl_pulse !== 0) begin tests_failed++; $display("FAIL pulse_width: got %0d long pulses required 0", dbl_pulse); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
